// File: rtl/delay15_pkg.sv
// delay15_pkg: shared constants and types for the delay15 delay line.
// Provides MAX_DELAY, DELAY_W and the delay_t tap-select type.
package delay15_pkg;

  localparam int MAX_DELAY = 15;
  localparam int DELAY_W   = $clog2(MAX_DELAY + 1);

  typedef logic [DELAY_W-1:0] delay_t;

endpackage

// File: rtl/delay15_if.sv
// delay15_if: bundle of the delay line data/select signals.
// master drives data_i/data_delay_i, slave returns data_o.
interface delay15_if
  import delay15_pkg::*;
#(
  parameter int DATA_W = 1
) ();

  logic [DATA_W-1:0] data_i;
  delay_t            data_delay_i;
  logic [DATA_W-1:0] data_o;

  modport master (
    output data_i,
    output data_delay_i,
    input  data_o
  );

  modport slave (
    input  data_i,
    input  data_delay_i,
    output data_o
  );

endinterface

// File: rtl/delay15_stage.sv
// delay15_stage: one DATA_W-bit shift stage, async active-low clear.
// Ports: clk_i, rst_i (0 = clear), d_i (next sample), q_o (stored).
module delay15_stage #(
  parameter int DATA_W = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;

  assign data_d = d_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/delay15.sv
// delay15: data_o is data_i delayed by data_delay_i (0..15) cycles.
// Ports: clk_i, rst_i (async, active-low), data_i, data_delay_i, data_o.
// Build option DELAY15_ZERO_BYPASS_EN: delay 0 passes data_i through
// combinationally; otherwise delay 0 yields a constant 0.
module delay15
  import delay15_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_i,
  input  delay_t            data_delay_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] tap [MAX_DELAY];

  // Free-running shift chain: tap[k] holds data_i from k+1 edges ago.
  for (genvar k = 0; k < MAX_DELAY; k++) begin : g_stage
    if (k == 0) begin : g_head
      delay15_stage #(.DATA_W(DATA_W)) u_stage (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (data_i),
        .q_o   (tap[k])
      );
    end else begin : g_body
      delay15_stage #(.DATA_W(DATA_W)) u_stage (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (tap[k-1]),
        .q_o   (tap[k])
      );
    end
  end

  // Tap mux retargets in the same cycle the select changes.
  always_comb begin
    data_o = '0;
    for (int k = 1; k <= MAX_DELAY; k++) begin
      if (data_delay_i == delay_t'(k)) begin
        data_o = tap[k-1];
      end
    end
`ifdef DELAY15_ZERO_BYPASS_EN
    if (data_delay_i == '0) begin
      data_o = data_i;
    end
`endif
  end

endmodule

// File: tb/tb_delay15.sv
// tb_delay15: randomized and directed bench for delay15 against a
// queue-based history model of past data_i samples.
module tb_delay15;
  import delay15_pkg::*;

  localparam int DATA_W = 1;

`ifdef DELAY15_ZERO_BYPASS_EN
  localparam bit ZB = 1'b1;
`else
  localparam bit ZB = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  delay15_if #(.DATA_W(DATA_W)) bus ();

  delay15 #(.DATA_W(DATA_W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .data_i       (bus.data_i),
    .data_delay_i (bus.data_delay_i),
    .data_o       (bus.data_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;

  // hist[0] is the most recent sample taken by a rising edge.
  logic [DATA_W-1:0] hist [$];

  task automatic check(string name,
                       logic [DATA_W-1:0] act,
                       logic [DATA_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hist.delete();
    end else begin
      hist.push_front(bus.data_i);
      if (hist.size() > MAX_DELAY) begin
        void'(hist.pop_back());
      end
    end
  end

  function automatic logic [DATA_W-1:0] model();
    int d;
    logic [DATA_W-1:0] r;
    d = int'(bus.data_delay_i);
    r = '0;
    if (d == 0) begin
      if (ZB) r = bus.data_i;
    end else if (d - 1 < hist.size()) begin
      r = hist[d-1];
    end
    return r;
  endfunction

  always @(negedge clk_i) begin
    check("model", bus.data_o, model());
  end

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin : main
    int d;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] drv [$];
    logic [4:0] pat;

    bus.data_i       = '0;
    bus.data_delay_i = '0;
    #1;
    rst_i            = 1'b0;
    bus.data_i       = 1'b1;
    bus.data_delay_i = delay_t'(5);

    repeat (4) begin
      @(negedge clk_i);
      check("rst_hold", bus.data_o, '0);
    end
    #1 rst_i = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("rst_rel k=%0d", k),
            bus.data_o, DATA_W'(k >= 5));
    end

    // Single-pulse sweep over every nonzero tap.
    for (int dd = 1; dd <= MAX_DELAY; dd++) begin
      #1;
      bus.data_i       = '0;
      bus.data_delay_i = delay_t'(dd);
      repeat (16) tick();
      #1 bus.data_i = 1'b1;
      for (int k = 1; k <= 17; k++) begin
        tick();
        check($sformatf("pulse d=%0d k=%0d", dd, k),
              bus.data_o, DATA_W'(k == dd));
        #1 bus.data_i = '0;
      end
    end

    // Random single-sample regression.
    for (int it = 0; it < 100; it++) begin
      d = int'($urandom_range(1, MAX_DELAY));
      b = DATA_W'($urandom);
      @(negedge clk_i);
      #1;
      bus.data_i       = b;
      bus.data_delay_i = delay_t'(d);
      tick();
      for (int k = 2; k <= d; k++) begin
        #1 bus.data_i = ~b;
        tick();
      end
      check($sformatf("rand d=%0d", d), bus.data_o, b);
    end

    // Mid-stream retarget from 8 to 3.
    pat = 5'b01101;
    @(negedge clk_i);
    #1 bus.data_delay_i = delay_t'(8);
    for (int i = 0; i < 20; i++) begin
      #1 bus.data_i = pat[i % 5];
      drv.push_back(pat[i % 5]);
      tick();
    end
    check("tap8", bus.data_o, drv[drv.size()-8]);
    #1 bus.data_delay_i = delay_t'(3);
    #1 check("retarget3", bus.data_o, drv[drv.size()-3]);
    repeat (6) begin
      #1 bus.data_i = ~bus.data_i;
      tick();
    end

    // Async reset mid-stream at the deepest tap.
    #1;
    bus.data_delay_i = delay_t'(15);
    bus.data_i       = 1'b1;
    repeat (20) tick();
    check("pre_rst15", bus.data_o, 1'b1);
    #2 rst_i = 1'b0;
    #1 check("async_rst", bus.data_o, '0);
    tick();
    #1;
    rst_i      = 1'b1;
    bus.data_i = '0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("no_stale k=%0d", k), bus.data_o, '0);
    end

    // Delay 0, in and out of reset.
    #1 bus.data_delay_i = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      #1 bus.data_i = DATA_W'(i & 1);
      #1 check($sformatf("zero i=%0d", i), bus.data_o,
               ZB ? DATA_W'(i & 1) : '0);
      #1 bus.data_i = DATA_W'(~i & 1);
      #1 check($sformatf("zero_mid i=%0d", i), bus.data_o,
               ZB ? DATA_W'(~i & 1) : '0);
    end
    tick();
    #1 rst_i = 1'b0;
    #1 bus.data_i = 1'b1;
    #1 check("zero_rst1", bus.data_o, ZB ? 1'b1 : 1'b0);
    #1 bus.data_i = 1'b0;
    #1 check("zero_rst0", bus.data_o, '0);
    tick();
    #1 rst_i = 1'b1;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/delay15.md
Name: delay15

Overview:
- Programmable delay line: data_o reproduces data_i delayed by a run-time selectable 0..15 clock cycles.
- Used wherever a control or data strobe must be realigned with a pipeline of variable depth.
- Internally a 15-deep shift register plus a tap-select mux driven by data_delay_i.

Parameters:
- DATA_W, 1, width of data_i/data_o in bits. Each bit is delayed identically.
- MAX_DELAY, 15, number of shift-register stages. Fixed at 15 for this block; data_delay_i is sized to match.

Ports:
- clk_i  input  1  single clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-low reset; 0 = reset asserted.
- data_i  input  DATA_W  sample shifted in every cycle.
- data_delay_i  input  4  selected delay in cycles, 0..15. May change at any cycle.
- data_o  output  DATA_W  data_i as sampled data_delay_i rising edges earlier.

Behaviour:
- Storage: stage[0..14], each DATA_W bits.
- Every rising edge with rst_i=1: stage[0] <= data_i; stage[k] <= stage[k-1] for k=1..14. The register shifts unconditionally; there is no enable.
- Output mux is purely combinational from the current stage contents and data_delay_i:
  - data_delay_i = d, with 1 <= d <= 15: data_o = stage[d-1].
  - data_delay_i = 0: see Optional Feature.
- Latency: a value presented on data_i before edge n appears on data_o after edge n+d-1. It is stable from just after edge n+d-1 until just after edge n+d. data_o therefore equals that sample when sampled at edge n+d, i.e. a delay of exactly d cycles.
- Changing data_delay_i mid-stream:
  - data_o retargets immediately, in the same cycle, to the new tap.
  - Shift history is preserved. There is no flush and no glitch suppression.
- Reset:
  - rst_i=0 asynchronously clears all stages to 0.
  - While in reset, data_o = 0 for every data_delay_i >= 1.
  - After release, data_o = 0 until real samples reach the selected tap.
- Reset mid-operation: all history is lost and the behaviour is identical to the post-reset condition.
- No handshake, no overflow or underflow conditions. All 4-bit data_delay_i values are legal.

Optional Feature:
- Macro: DELAY15_ZERO_BYPASS_EN.
- Defined: data_delay_i = 0 gives data_o = data_i as a combinational pass-through. This also applies during reset.
- Not defined: data_delay_i = 0 gives data_o = 0, a constant.
- The 1..15 behaviour is identical in both builds.

Decomposition:
- Package delay15_pkg:
  - localparam MAX_DELAY = 15.
  - localparam DELAY_W = $clog2(MAX_DELAY+1) = 4.
  - typedef logic [DELAY_W-1:0] delay_t, used for data_delay_i.
- One natural sub-module: delay15_stage, a single DATA_W-bit flop with async active-low clear, instantiated 15 times in a generate loop.
- The tap mux stays in the top level.

Test Plan:
- Reset: hold rst_i=0 with data_i=1 and data_delay_i=5 -> data_o=0 throughout. After release, data_o stays 0 for 5 cycles.
- Single-pulse sweep: for d=1..15, drive data_i=1 for one cycle and then 0 -> data_o=1 sampled exactly d edges later, and 0 at every other sampled edge.
- Random regression: 100 iterations of random d in 1..15 and random bit b. Drive b, then !b for d-1 cycles -> data_o==b at edge d, otherwise fail with d, expected and actual values reported.
- Mid-stream delay change: stream pattern 1,0,1,1,0,... at d=8, then switch to d=3 -> data_o immediately shows stage[2]. No reset of history.
- Async reset mid-stream: pulse rst_i=0 between edges while streaming with d=15 -> data_o drops to 0 at once without a clock edge. Old data never reappears.
- Delay 0:
  - With DELAY15_ZERO_BYPASS_EN defined: toggle data_i between edges -> data_o follows in zero time.
  - Without it: data_o=0 constant.
